// File: rtl/shift_xfer_ctrl_if.sv
// Handshake and serial-loop signals between a parallel producer/consumer and shift_xfer_ctrl.
// Latency: none, wires only; backpressure: start_ready/rx_ready carry it.
interface shift_xfer_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] tx_data;
  logic             abort;
  logic             shift_ena;
  logic             sout;
  logic             sin;
  logic             busy;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             aborted;

  modport master (
    output start_valid, tx_data, abort, sin, rx_ready,
    input  start_ready, shift_ena, sout, busy, rx_valid, rx_data, aborted
  );

  modport slave (
    input  start_valid, tx_data, abort, sin, rx_ready,
    output start_ready, shift_ena, sout, busy, rx_valid, rx_data, aborted
  );
endinterface

// File: rtl/shift_xfer_ctrl.sv
// Shifts a word MSB-first through an external serial loop and recaptures it; accept to rx_valid
// is WIDTH+LOOP_LAT+GAP_CYCLES+1 cycles; rx_data holds in DONE until rx_ready, start_ready only in IDLE.
module shift_xfer_ctrl #(
  parameter int WIDTH      = 8,
  parameter int LOOP_LAT   = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  shift_xfer_ctrl_if.slave bus
);
  localparam int N  = WIDTH + LOOP_LAT;
  localparam int CW = $clog2(N + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] RX_FIRST = CW'(LOOP_LAT);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [GW-1:0]    r_gap_cnt, w_gap_cnt;
  logic [WIDTH-1:0] r_tx_sr, w_tx_sr;
  logic [WIDTH-1:0] r_rx_sr, w_rx_sr;
  logic [WIDTH-1:0] r_rx_data, w_rx_data;
  logic [WIDTH-1:0] w_rx_shift;
  logic             r_start_ready, r_shift_ena, r_sout, r_busy, r_rx_valid, r_aborted;
  logic             w_sout, w_aborted;

  assign w_rx_shift = (r_rx_sr << 1) | WIDTH'(bus.sin);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt       = r_cnt;
    w_gap_cnt   = r_gap_cnt;
    w_tx_sr     = r_tx_sr;
    w_rx_sr     = r_rx_sr;
    w_rx_data   = r_rx_data;
    w_sout      = 1'b0;
    w_aborted   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_valid && r_start_ready) begin
          w_state_nxt = SHIFT;
          w_cnt       = '0;
          w_tx_sr     = bus.tx_data << 1;
          w_rx_sr     = '0;
          w_sout      = bus.tx_data[WIDTH-1];
        end
      end
      SHIFT: begin
        w_cnt   = r_cnt + 1'b1;
        w_tx_sr = r_tx_sr << 1;
        w_sout  = r_tx_sr[WIDTH-1];
        // The returned stream only carries our bits once the loop latency has elapsed.
        if (r_cnt >= RX_FIRST) w_rx_sr = w_rx_shift;
        if (r_cnt == CNT_LAST) begin
          w_sout      = 1'b0;
          w_gap_cnt   = '0;
          w_state_nxt = (GAP_CYCLES > 0) ? GAP : DONE;
        end
      end
      GAP: begin
        w_gap_cnt = r_gap_cnt + 1'b1;
        if (r_gap_cnt == GAP_LAST) w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.rx_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (r_state != IDLE && bus.abort) begin
      w_state_nxt = IDLE;
      w_aborted   = 1'b1;
      w_sout      = 1'b0;
    end
    if (w_state_nxt == DONE && r_state != DONE) w_rx_data = w_rx_sr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_gap_cnt     <= '0;
      r_tx_sr       <= '0;
      r_rx_sr       <= '0;
      r_rx_data     <= '0;
      r_start_ready <= 1'b0;
      r_shift_ena   <= 1'b0;
      r_sout        <= 1'b0;
      r_busy        <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt;
      r_gap_cnt     <= w_gap_cnt;
      r_tx_sr       <= w_tx_sr;
      r_rx_sr       <= w_rx_sr;
      r_rx_data     <= w_rx_data;
      r_start_ready <= (w_state_nxt == IDLE);
      r_shift_ena   <= (w_state_nxt == SHIFT);
      r_sout        <= w_sout;
      r_busy        <= (w_state_nxt != IDLE);
      r_rx_valid    <= (w_state_nxt == DONE);
      r_aborted     <= w_aborted;
    end
  end

  assign bus.start_ready = r_start_ready;
  assign bus.shift_ena   = r_shift_ena;
  assign bus.sout        = r_sout;
  assign bus.busy        = r_busy;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.rx_data     = r_rx_data;
  assign bus.aborted     = r_aborted;
endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Directed bench for shift_xfer_ctrl with sout looped back through a 4-stage enabled shift register.
module tb_shift_xfer_ctrl;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] lb;
  int         n_cmp = 0;
  int         n_bad = 0;

  shift_xfer_ctrl_if #(.WIDTH(8)) bus ();

  shift_xfer_ctrl #(.WIDTH(8), .LOOP_LAT(4), .GAP_CYCLES(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) lb <= 4'b0;
    else if (bus.shift_ena) lb <= {lb[2:0], bus.sout};
  end
  assign bus.sin = lb[3];

  task automatic test_reset();
    bus.start_valid = 1'b0; bus.tx_data = 8'h00; bus.abort = 1'b0; bus.rx_ready = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.start_ready !== 1'b0) begin n_bad++; $display("FAIL rst_start_ready got=%b want=0", bus.start_ready); end
    n_cmp++; if ({bus.shift_ena, bus.sout, bus.busy, bus.rx_valid, bus.aborted} !== 5'b0) begin
      n_bad++; $display("FAIL rst_outputs got=%b want=00000", {bus.shift_ena, bus.sout, bus.busy, bus.rx_valid, bus.aborted}); end
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_bad++; $display("FAIL rst_rx_data got=%h want=00", bus.rx_data); end
    resetn = 1'b1;
    #1;
    n_cmp++; if (bus.start_ready !== 1'b0) begin n_bad++; $display("FAIL rst_first_cycle_ready got=%b want=0", bus.start_ready); end
    @(negedge clk);
    n_cmp++; if (bus.start_ready !== 1'b1) begin n_bad++; $display("FAIL rst_second_cycle_ready got=%b want=1", bus.start_ready); end
    n_cmp++; if ({bus.shift_ena, bus.sout, bus.busy, bus.rx_valid, bus.aborted} !== 5'b0) begin
      n_bad++; $display("FAIL rst_post_outputs got=%b want=00000", {bus.shift_ena, bus.sout, bus.busy, bus.rx_valid, bus.aborted}); end
  endtask

  task automatic test_single();
    logic [11:0] exp_sout;
    exp_sout = 12'b1010_0101_0000;
    bus.rx_ready = 1'b1; bus.abort = 1'b0;
    n_cmp++; if (bus.start_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_idle got=%b want=1", bus.start_ready); end
    bus.start_valid = 1'b1; bus.tx_data = 8'hA5;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
      n_cmp++; if (bus.shift_ena !== 1'b1) begin n_bad++; $display("FAIL single_shift_ena c%0d got=%b want=1", i, bus.shift_ena); end
      n_cmp++; if (bus.sout !== exp_sout[11-i]) begin n_bad++; $display("FAIL single_sout c%0d got=%b want=%b", i, bus.sout, exp_sout[11-i]); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if ({bus.shift_ena, bus.sout, bus.busy, bus.rx_valid} !== 4'b0010) begin
        n_bad++; $display("FAIL single_gap c%0d got=%b want=0010", i, {bus.shift_ena, bus.sout, bus.busy, bus.rx_valid}); end
    end
    @(negedge clk);
    n_cmp++; if (bus.rx_valid !== 1'b1) begin n_bad++; $display("FAIL single_rx_valid got=%b want=1", bus.rx_valid); end
    n_cmp++; if (bus.rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_rx_data got=%h want=a5", bus.rx_data); end
    @(negedge clk);
    n_cmp++; if ({bus.rx_valid, bus.start_ready, bus.busy} !== 3'b010) begin
      n_bad++; $display("FAIL single_after got=%b want=010", {bus.rx_valid, bus.start_ready, bus.busy}); end
    n_cmp++; if (bus.rx_data !== 8'hA5) begin n_bad++; $display("FAIL single_rx_hold got=%h want=a5", bus.rx_data); end
  endtask

  task automatic test_hold();
    bus.rx_ready = 1'b0;
    bus.start_valid = 1'b1; bus.tx_data = 8'h3C;
    repeat (14) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      n_cmp++; if (bus.rx_valid !== 1'b1) begin n_bad++; $display("FAIL hold_rx_valid c%0d got=%b want=1", j, bus.rx_valid); end
      n_cmp++; if (bus.rx_data !== 8'h3C) begin n_bad++; $display("FAIL hold_rx_data c%0d got=%h want=3c", j, bus.rx_data); end
      n_cmp++; if (bus.start_ready !== 1'b0) begin n_bad++; $display("FAIL hold_start_ready c%0d got=%b want=0", j, bus.start_ready); end
      if (j == 0) begin bus.start_valid = 1'b1; bus.tx_data = 8'h11; end
      if (j == 1) bus.start_valid = 1'b0;
      if (j == 5) bus.rx_ready = 1'b1;
    end
    @(negedge clk);
    n_cmp++; if ({bus.rx_valid, bus.start_ready, bus.shift_ena, bus.busy} !== 4'b0100) begin
      n_bad++; $display("FAIL hold_release got=%b want=0100", {bus.rx_valid, bus.start_ready, bus.shift_ena, bus.busy}); end
    n_cmp++; if (bus.rx_data !== 8'h3C) begin n_bad++; $display("FAIL hold_rx_keep got=%h want=3c", bus.rx_data); end
  endtask

  task automatic test_abort_shift();
    bus.rx_ready = 1'b1; bus.abort = 1'b0;
    bus.start_valid = 1'b1; bus.tx_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
      n_cmp++; if (bus.shift_ena !== 1'b1) begin n_bad++; $display("FAIL abs_shift_ena c%0d got=%b want=1", i, bus.shift_ena); end
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_cmp++; if ({bus.shift_ena, bus.aborted, bus.busy, bus.rx_valid} !== 4'b0100) begin
      n_bad++; $display("FAIL abs_after got=%b want=0100", {bus.shift_ena, bus.aborted, bus.busy, bus.rx_valid}); end
    n_cmp++; if (bus.rx_data !== 8'h3C) begin n_bad++; $display("FAIL abs_rx_data got=%h want=3c", bus.rx_data); end
    @(negedge clk);
    n_cmp++; if ({bus.aborted, bus.start_ready} !== 2'b01) begin
      n_bad++; $display("FAIL abs_pulse_end got=%b want=01", {bus.aborted, bus.start_ready}); end
  endtask

  task automatic test_abort_done();
    bus.rx_ready = 1'b0;
    bus.start_valid = 1'b1; bus.tx_data = 8'hC3;
    repeat (15) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
    end
    n_cmp++; if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'hC3}) begin
      n_bad++; $display("FAIL abd_done got=%b/%h want=1/c3", bus.rx_valid, bus.rx_data); end
    bus.abort = 1'b1; bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_cmp++; if ({bus.rx_valid, bus.aborted, bus.start_ready} !== 3'b011) begin
      n_bad++; $display("FAIL abd_after got=%b want=011", {bus.rx_valid, bus.aborted, bus.start_ready}); end
    n_cmp++; if (bus.rx_data !== 8'hC3) begin n_bad++; $display("FAIL abd_rx_data got=%h want=c3", bus.rx_data); end
    @(negedge clk);
    n_cmp++; if (bus.aborted !== 1'b0) begin n_bad++; $display("FAIL abd_pulse_end got=%b want=0", bus.aborted); end
  endtask

  task automatic test_abort_idle();
    bus.rx_ready = 1'b1;
    bus.abort = 1'b1; bus.start_valid = 1'b1; bus.tx_data = 8'h81;
    @(negedge clk);
    bus.abort = 1'b0; bus.start_valid = 1'b0;
    n_cmp++; if ({bus.shift_ena, bus.aborted, bus.sout} !== 3'b101) begin
      n_bad++; $display("FAIL abi_accept got=%b want=101", {bus.shift_ena, bus.aborted, bus.sout}); end
    repeat (14) @(negedge clk);
    n_cmp++; if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'h81}) begin
      n_bad++; $display("FAIL abi_rx got=%b/%h want=1/81", bus.rx_valid, bus.rx_data); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    bus.rx_ready = 1'b1;
    bus.start_valid = 1'b1; bus.tx_data = 8'h96;
    repeat (6) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
    end
    resetn = 1'b0;
    #1;
    n_cmp++; if ({bus.start_ready, bus.shift_ena, bus.sout, bus.busy, bus.rx_valid, bus.aborted} !== 6'b0) begin
      n_bad++; $display("FAIL arst_outputs got=%b want=000000",
        {bus.start_ready, bus.shift_ena, bus.sout, bus.busy, bus.rx_valid, bus.aborted}); end
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_bad++; $display("FAIL arst_rx_data got=%h want=00", bus.rx_data); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus.start_ready, bus.shift_ena, bus.busy, bus.rx_valid} !== 4'b1000) begin
      n_bad++; $display("FAIL arst_release got=%b want=1000", {bus.start_ready, bus.shift_ena, bus.busy, bus.rx_valid}); end
  endtask

  task automatic test_back_to_back();
    int         acc_n;
    int         rx_n;
    int         acc_t [0:1];
    logic [7:0] rx_w  [0:1];
    acc_n = 0; rx_n = 0;
    acc_t[0] = -100; acc_t[1] = 0;
    rx_w[0] = 8'hXX; rx_w[1] = 8'hXX;
    bus.rx_ready = 1'b1; bus.abort = 1'b0;
    bus.start_valid = 1'b1; bus.tx_data = 8'hFF;
    for (int t = 0; t < 40; t++) begin
      if (bus.rx_valid) begin
        if (rx_n < 2) rx_w[rx_n] = bus.rx_data;
        rx_n++;
      end
      if (bus.start_valid && bus.start_ready) begin
        if (acc_n < 2) acc_t[acc_n] = t;
        acc_n++;
      end else if (acc_n == 1) begin
        bus.tx_data = 8'h00;
      end
      if (acc_n == 2 && t > acc_t[1]) bus.start_valid = 1'b0;
      @(negedge clk);
    end
    bus.start_valid = 1'b0;
    n_cmp++; if (acc_n !== 2) begin n_bad++; $display("FAIL b2b_accepts got=%0d want=2", acc_n); end
    n_cmp++; if (acc_t[1] - acc_t[0] !== 16) begin n_bad++; $display("FAIL b2b_spacing got=%0d want=16", acc_t[1] - acc_t[0]); end
    n_cmp++; if (rx_n !== 2) begin n_bad++; $display("FAIL b2b_rx_count got=%0d want=2", rx_n); end
    n_cmp++; if (rx_w[0] !== 8'hFF) begin n_bad++; $display("FAIL b2b_rx0 got=%h want=ff", rx_w[0]); end
    n_cmp++; if (rx_w[1] !== 8'h00) begin n_bad++; $display("FAIL b2b_rx1 got=%h want=00", rx_w[1]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_abort_shift();
    test_abort_done();
    test_abort_idle();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
